tanh_controller: RTL and testbench

Sequencer for the tanh(x) Maclaurin datapath. It accepts one operand per start pulse, steps the datapath's 3-bit coefficient address, and evaluates the 8-term odd series by Horner's method on x². It applies the sign and drives the 32-bit `result_ready` word that `Datapath` registers as `result`. It sits between the host handshake and `Datapath` and owns all sequencing, multiplication and accumulation.

---
 rtl/tanh_pkg.sv | 31 +++
 rtl/tanh_mac.sv | 21 ++
 rtl/tanh_controller.sv | 127 ++++++++++++
 tb/tb_tanh_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh(x) series sequencer.
package tanh_pkg;

  localparam int unsigned N_TERMS = 8;
  localparam int unsigned XW      = 16;
  localparam int unsigned ACCW    = 20;
  localparam int unsigned LUTW    = 17;
  localparam int unsigned RESW    = 32;
  localparam int unsigned AW      = $clog2(N_TERMS);
  localparam int unsigned PRODW   = ACCW + XW;

  localparam logic [XW-1:0] LINEAR_THRESH = 16'h0100;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    LOAD,
    MAC,
    SCALE,
    DONE
  } state_t;

  // Odd-index Maclaurin terms of tanh carry a negative sign.
  function automatic logic signed [ACCW-1:0] signed_coef(input logic [LUTW-1:0] mag,
                                                        input logic            neg);
    logic signed [ACCW-1:0] v;
    v = signed'({{(ACCW-LUTW){1'b0}}, mag});
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/tanh_mac.sv
// Combinational signed multiply by an unsigned Q0.16 operand, arithmetic
// truncate by 16, then add: sum = c + ((a * b) >>> 16).
module tanh_mac
  import tanh_pkg::*;
(
  input  logic signed [ACCW-1:0] a,
  input  logic        [XW-1:0]   b,
  input  logic signed [ACCW-1:0] c,
  output logic signed [ACCW-1:0] sum_c
);

  logic signed [PRODW-1:0] prod_c;
  logic signed [PRODW-1:0] shifted_c;

  always_comb begin
    prod_c    = PRODW'(a) * PRODW'($signed({1'b0, b}));
    shifted_c = prod_c >>> 16;
    sum_c     = c + ACCW'(shifted_c);
  end

endmodule

// File: rtl/tanh_controller.sv
// Sequencer for the 8-term tanh(x) Maclaurin series (Horner on x^2).
// Optional `TANH_LINEAR_EN: operands below LINEAR_THRESH bypass the series.
module tanh_controller
  import tanh_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XW-1:0]   x_in,
  input  logic            x_sign,
  input  logic [LUTW-1:0] lut,
  output logic [AW-1:0]   addr,
  output logic [RESW-1:0] result_ready,
  output logic            busy,
  output logic            done
);

  state_t                 state;
  logic [XW-1:0]          x_q;
  logic                   sign_q;
  logic [XW-1:0]          y_q;
  logic signed [ACCW-1:0] acc;

  logic [2*XW-1:0]        sq_c;
  logic signed [ACCW-1:0] coef_c;
  logic [XW-1:0]          mac_b_c;
  logic signed [ACCW-1:0] mac_c_c;
  logic signed [ACCW-1:0] mac_sum_c;
  logic signed [RESW-1:0] r_c;
`ifdef TANH_LINEAR_EN
  logic signed [RESW-1:0] lin_c;
`endif

  assign coef_c = signed_coef(lut, addr[0]);

  // The multiplier is shared: Horner step in MAC, final x scaling in SCALE.
  always_comb begin
    mac_b_c = y_q;
    mac_c_c = coef_c;
    if (state == SCALE) begin
      mac_b_c = x_q;
      mac_c_c = '0;
    end
    sq_c = {{XW{1'b0}}, x_q} * {{XW{1'b0}}, x_q};
    r_c  = {{(RESW-ACCW){mac_sum_c[ACCW-1]}}, mac_sum_c};
`ifdef TANH_LINEAR_EN
    lin_c = signed'({{(RESW-XW){1'b0}}, x_in});
`endif
  end

  tanh_mac u_mac (
    .a     (acc),
    .b     (mac_b_c),
    .c     (mac_c_c),
    .sum_c (mac_sum_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      result_ready <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      x_q          <= '0;
      sign_q       <= 1'b0;
      y_q          <= '0;
      acc          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_q    <= x_in;
            sign_q <= x_sign;
            addr   <= '0;
            busy   <= 1'b1;
`ifdef TANH_LINEAR_EN
            if (x_in < LINEAR_THRESH) begin
              result_ready <= x_sign ? -lin_c : lin_c;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              state <= SQUARE;
            end
`else
            state <= SQUARE;
`endif
          end
        end
        SQUARE: begin
          y_q   <= XW'(sq_c >> XW);
          addr  <= AW'(N_TERMS - 1);
          state <= LOAD;
        end
        LOAD: begin
          acc   <= coef_c;
          addr  <= addr - AW'(1);
          state <= MAC;
        end
        MAC: begin
          acc <= mac_sum_c;
          if (addr == '0) begin
            state <= SCALE;
          end else begin
            addr <= addr - AW'(1);
          end
        end
        SCALE: begin
          result_ready <= sign_q ? -r_c : r_c;
          done         <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          addr  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_controller.sv
// Self-checking bench for tanh_controller: directed cases plus random operands
// against a plain-arithmetic model of the tanh Maclaurin series.
module tb_tanh_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x_in;
  logic        x_sign;
  logic [16:0] lut;
  logic [2:0]  addr;
  logic [31:0] result_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

`ifdef TANH_LINEAR_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif

  // Datapath coefficient ROM: |c_k| of tanh in Q1.16, for x * sum c_k (x^2)^k.
  logic [16:0] lut_rom [8] = '{17'd65536, 17'd21845, 17'd8738, 17'd3537,
                               17'd1433,  17'd581,   17'd235,  17'd95};

  logic [2:0]  addr_log [8];
  logic [31:0] res;
  int          lat;
  int          ndone;

  assign lut = lut_rom[addr];

  tanh_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .x_in         (x_in),
    .x_sign       (x_sign),
    .lut          (lut),
    .addr         (addr),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // tanh(x) ~= x * sum_k (-1)^k c_k y^k, y = x^2, evaluated innermost-first
  // with floor-truncating Q16 products.
  function automatic logic [31:0] model(input logic [15:0] x, input logic s);
    longint xv, y, acc, r, c;
    xv = longint'(x);
    if (LIN && x < 16'h0100) begin
      r = s ? -xv : xv;
      return 32'(r);
    end
    y   = (xv * xv) >>> 16;
    acc = -longint'(lut_rom[7]);
    for (int k = 6; k >= 0; k--) begin
      c   = longint'(lut_rom[k]);
      if (k % 2 == 1) c = -c;
      acc = c + ((acc * y) >>> 16);
    end
    r = (acc * xv) >>> 16;
    if (s) r = -r;
    return 32'(r);
  endfunction

  function automatic int exp_lat(input logic [15:0] x);
    return (LIN && x < 16'h0100) ? 0 : 10;
  endfunction

  // Edge 0 samples start; lat is the edge index after which done is seen.
  task automatic run_op(input logic [15:0] x, input logic s, input int extra);
    lat   = -1;
    ndone = 0;
    res   = 'x;
    x_in   = x;
    x_sign = s;
    for (int e = 0; e <= 16; e++) begin
      start = (e == 0) || (e == extra);
      tick();
      if (e == 0) begin
        x_in   = 16'($urandom);
        x_sign = 1'($urandom);
      end
      if (e >= 1 && e <= 8) addr_log[e-1] = addr;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = e;
          res = result_ready;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] pos_res;
    logic [15:0] rx;
    logic        rs;
    int          diff;

    rst    = 1'b1;
    start  = 1'b0;
    x_in   = '0;
    x_sign = 1'b0;
    repeat (3) tick();
    check("reset_addr",   32'(addr), 32'd0);
    check("reset_result", result_ready, 32'd0);
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    rst = 1'b0;

    // Reset mid-run: start held high on the reset edge must not restart.
    x_in   = 16'h8000;
    x_sign = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    repeat (4) begin
      tick();
      if (done) ndone++;
    end
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("midrst_addr",   32'(addr), 32'd0);
    check("midrst_result", result_ready, 32'd0);
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_done",   32'(done), 32'd0);
    repeat (3) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(16'h9000, 1'b0, -1);
    check("midrst_fresh_lat", 32'(lat), 32'd10);
    check("midrst_fresh_res", res, model(16'h9000, 1'b0));

    // Zero operand and coefficient address order.
    run_op(16'h0000, 1'b0, -1);
    check("zero_lat", 32'(lat), 32'd10);
    check("zero_res", res, 32'h0000_0000);
    for (int i = 0; i < 8; i++)
      check($sformatf("zero_addr_e%0d", i + 1), 32'(addr_log[i]), 32'(7 - i));

    // tanh(0.5) and its negative.
    run_op(16'h8000, 1'b0, -1);
    pos_res = res;
    check("pos_half_lat", 32'(lat), 32'd10);
    check("pos_half_model", res, model(16'h8000, 1'b0));
    diff = int'(signed'(res)) - 32'h0000_764D;
    check("pos_half_tol", 32'(diff >= -4 && diff <= 4), 32'd1);
    run_op(16'h8000, 1'b1, -1);
    check("neg_half_twos", res, -pos_res);
    check("neg_half_model", res, model(16'h8000, 1'b1));

    // Near one, with a second start during the run.
    run_op(16'hFFFF, 1'b0, 4);
    check("near_one_lat", 32'(lat), 32'd10);
    check("near_one_ndone", 32'(ndone), 32'd1);
    check("near_one_model", res, model(16'hFFFF, 1'b0));
    diff = int'(signed'(res)) - 32'h0000_C2F8;
    check("near_one_tol", 32'(diff >= -40 && diff <= 40), 32'd1);
    check("near_one_hold", result_ready, res);
    check("near_one_idle", 32'(busy), 32'd0);

    // Linear region operand.
    run_op(16'h0080, 1'b0, -1);
    check("linear_lat", 32'(lat), 32'(exp_lat(16'h0080)));
    check("linear_res", res, 32'h0000_0080);

    // Random operands, including some in the linear region.
    for (int n = 0; n < 16; n++) begin
      rx = (n % 4 == 0) ? 16'($urandom_range(0, 511)) : 16'($urandom);
      rs = 1'($urandom);
      run_op(rx, rs, -1);
      check($sformatf("rand%0d_lat x=%h", n, rx), 32'(lat), 32'(exp_lat(rx)));
      check($sformatf("rand%0d_res x=%h s=%0d", n, rx, rs), res, model(rx, rs));
      check($sformatf("rand%0d_hold", n), result_ready, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
